// File: rtl/detector_arbiter.sv
// Round-robin scheduler sharing one serial sequence detector among N_REQ lanes.
// Optional early exit on the first detector hit is enabled by defining DETARB_EARLY_EXIT_EN.
module detector_arbiter #(
   parameter int N_REQ     = 4,
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           lane_x,
   output logic [N_REQ-1:0]           grant,
   output logic                       busy,
   output logic                       det_x,
   output logic                       det_rst,
   input  logic                       det_z,
   output logic                       done,
   output logic [$clog2(N_REQ)-1:0]   done_id,
   output logic [CNT_W-1:0]           match_cnt
);

   localparam int IDW = $clog2(N_REQ);
   localparam int BCW = $clog2(FRAME_LEN);

   // Handshake: a lane holds req high until it sees done with its done_id; the grant
   // is taken only in IDLE and stays fixed until REPORT, whatever req does meanwhile.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_REPORT = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [N_REQ-1:0]   r_grant;
   logic [IDW-1:0]     r_gnt_idx;
   logic [IDW-1:0]     r_rr;
   logic [BCW-1:0]     r_bit_cnt;
   logic [CNT_W-1:0]   r_hit_cnt;
   logic [IDW-1:0]     r_done_id;
   logic [CNT_W-1:0]   r_match_cnt;
   logic               r_rst_hold;

   logic [IDW-1:0]     w_pick;
   logic               w_last_bit;
   logic               w_sample;
   logic               w_hit;
   logic [CNT_W-1:0]   w_hit_next;

   function automatic logic [IDW-1:0] f_pick(input logic [N_REQ-1:0] r, input logic [IDW-1:0] p);
      logic [IDW-1:0] sel;
      logic           found;
      int             idx;
      sel   = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(p) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && r[idx]) begin
            found = 1'b1;
            sel   = IDW'(idx);
         end
      end
      return sel;
   endfunction

   assign w_pick     = f_pick(req, r_rr);
   assign w_last_bit = (r_bit_cnt == BCW'(FRAME_LEN - 1));
   // The detector answers one cycle late, so stream cycle 0 carries no result.
   assign w_sample   = ((r_state == S_STREAM) && (r_bit_cnt != '0)) || (r_state == S_DRAIN);
   assign w_hit      = w_sample && det_z;
   assign w_hit_next = (w_hit && (r_hit_cnt != {CNT_W{1'b1}})) ? r_hit_cnt + 1'b1 : r_hit_cnt;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (|req) w_next_state = S_CLEAR;
         S_CLEAR:  w_next_state = S_STREAM;
         S_STREAM: begin
`ifdef DETARB_EARLY_EXIT_EN
            if (w_hit)           w_next_state = S_REPORT;
            else if (w_last_bit) w_next_state = S_DRAIN;
`else
            if (w_last_bit)      w_next_state = S_DRAIN;
`endif
         end
         S_DRAIN:  w_next_state = S_REPORT;
         S_REPORT: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_grant     <= '0;
         r_gnt_idx   <= '0;
         r_rr        <= '0;
         r_bit_cnt   <= '0;
         r_hit_cnt   <= '0;
         r_done_id   <= '0;
         r_match_cnt <= '0;
         r_rst_hold  <= 1'b1;
      end else begin
         r_rst_hold <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
                  r_gnt_idx <= w_pick;
               end
            end
            S_CLEAR: begin
               r_bit_cnt <= '0;
               r_hit_cnt <= '0;
            end
            S_STREAM: begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
               r_hit_cnt <= w_hit_next;
            end
            S_DRAIN:  r_hit_cnt <= w_hit_next;
            S_REPORT: r_rr <= (r_gnt_idx == IDW'(N_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
            default:  ;
         endcase
         // Result registers capture on entry to REPORT so they include the final sample.
         if (w_next_state == S_REPORT) begin
            r_grant     <= '0;
            r_done_id   <= r_gnt_idx;
            r_match_cnt <= w_hit_next;
         end
      end
   end

   always_comb begin
      busy      = (r_state != S_IDLE);
      det_rst   = r_rst_hold || (r_state == S_CLEAR);
      det_x     = (r_state == S_STREAM) ? lane_x[r_gnt_idx] : 1'b0;
      done      = (r_state == S_REPORT);
      grant     = r_grant;
      done_id   = r_done_id;
      match_cnt = r_match_cnt;
   end

endmodule

// File: tb/tb_detector_arbiter.sv
// Self-checking bench for detector_arbiter: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_detector_arbiter;

   localparam int N    = 4;
   localparam int F    = 8;
   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  lane_x = '0;
   logic          det_z = 1'b0;
   logic [N-1:0]  grant;
   logic          busy;
   logic          det_x;
   logic          det_rst;
   logic          done;
   logic [1:0]    done_id;
   logic [CW-1:0] match_cnt;

   int n_cmp  = 0;
   int n_fail = 0;
   int m_rr   = 0;
   logic [CW-1:0] exp_q[$];

   detector_arbiter #(.N_REQ(N), .FRAME_LEN(F), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .req(req), .lane_x(lane_x), .grant(grant), .busy(busy),
      .det_x(det_x), .det_rst(det_rst), .det_z(det_z), .done(done), .done_id(done_id),
      .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $error("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Round-robin choice: first requesting lane at or after the pointer, with wrap.
   function automatic int pick(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++)
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   // Expected count for a frame given z per stream cycle (bits 0..F-1) and drain (bit F).
   // exit_k is the stream cycle after which the frame jumps to REPORT (F+1 = no early jump).
   function automatic int hits(input logic [F:0] z, output int exit_k);
      int c;
      c      = 0;
      exit_k = F + 1;
`ifdef DETARB_EARLY_EXIT_EN
      for (int k = 1; k <= F; k++) begin
         if (z[k]) begin
            if (k < F) exit_k = k;
            return 1;
         end
      end
      return 0;
`else
      for (int k = 1; k <= F; k++)
         if (z[k] && c < MAXC) c++;
      return c;
`endif
   endfunction

   task automatic run_frame(input logic [N-1:0] r, input logic [F:0] z, input bit keep);
      int g;
      int ek;
      int ec;
      g  = pick(r, m_rr);
      ec = hits(z, ek);
      exp_q.push_back(CW'(ec));
      req = r;
      @(posedge clk); @(negedge clk);
      check("clear_grant", 32'(grant), 32'(1) << g);
      check("clear_det_rst", 32'(det_rst), 1);
      check("clear_busy", 32'(busy), 1);
      check("clear_det_x", 32'(det_x), 0);
      if (!keep) req = N'($urandom);
      for (int k = 0; k < F; k++) begin
         @(posedge clk); @(negedge clk);
         lane_x = N'($urandom);
         det_z  = z[k];
         #1;
         check("stream_det_x", 32'(det_x), 32'(lane_x[g]));
         check("stream_det_rst", 32'(det_rst), 0);
         check("stream_done", 32'(done), 0);
         check("stream_grant", 32'(grant), 32'(1) << g);
         if (k == ek) break;
      end
      if (ek > F - 1) begin
         @(posedge clk); @(negedge clk);
         lane_x = N'($urandom);
         det_z  = z[F];
         #1;
         check("drain_det_x", 32'(det_x), 0);
         check("drain_done", 32'(done), 0);
         check("drain_busy", 32'(busy), 1);
      end
      @(posedge clk); @(negedge clk);
      det_z = 1'b0;
      check("report_done", 32'(done), 1);
      check("report_done_id", 32'(done_id), 32'(g));
      check("report_match_cnt", 32'(match_cnt), 32'(exp_q.pop_front()));
      check("report_grant", 32'(grant), 0);
      check("report_busy", 32'(busy), 1);
      m_rr = (g + 1) % N;
      if (!keep) req = '0;
      @(posedge clk); @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(done), 0);
      check("idle_det_rst", 32'(det_rst), 0);
      check("idle_hold_cnt", 32'(match_cnt), 32'(ec));
      check("idle_hold_id", 32'(done_id), 32'(g));
   endtask

   initial begin
      int g;
      // reset with all lanes requesting
      rst = 1'b0;
      req = 4'b1111;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_grant", 32'(grant), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_det_rst", 32'(det_rst), 1);
      check("rst_done", 32'(done), 0);
      check("rst_det_x", 32'(det_x), 0);
      check("rst_done_id", 32'(done_id), 0);
      check("rst_match_cnt", 32'(match_cnt), 0);
      rst  = 1'b1;
      m_rr = 0;

      // round robin with req held: lanes 0,1,2,3,0
      run_frame(4'b1111, 9'h000, 1'b1);
      run_frame(4'b1111, 9'(($urandom & 32'h1FF)), 1'b1);
      run_frame(4'b1111, 9'(($urandom & 32'h1FF)), 1'b1);
      run_frame(4'b1111, 9'(($urandom & 32'h1FF)), 1'b1);
      run_frame(4'b1111, 9'(($urandom & 32'h1FF)), 1'b0);

      // single lane, hits in stream cycles 3 and 6
      run_frame(4'b0100, 9'b0_0100_1000, 1'b0);
      // saturation, cycle-0-only hit, drain-only hit, hit at stream cycle 2
      run_frame(4'b1001, 9'h1FF, 1'b0);
      run_frame(4'b0001, 9'h001, 1'b0);
      run_frame(4'b0010, 9'h100, 1'b0);
      run_frame(4'b0100, 9'h004, 1'b0);

      // reset in stream cycle 4: frame lost, pointer back to lane 0
      req = 4'b1000;
      g   = pick(req, m_rr);
      @(posedge clk); @(negedge clk);
      check("mid_clear_grant", 32'(grant), 32'(1) << g);
      for (int k = 0; k <= 4; k++) begin
         @(posedge clk); @(negedge clk);
         lane_x = N'($urandom);
         det_z  = 1'b0;
         if (k == 4) rst = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      check("mid_rst_grant", 32'(grant), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_det_rst", 32'(det_rst), 1);
      req  = '0;
      m_rr = 0;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      run_frame(4'b1010, 9'(($urandom & 32'h1FF)), 1'b0);
      run_frame(4'b0010, 9'(($urandom & 32'h1FF)), 1'b0);

      // randomized frames
      for (int i = 0; i < 24; i++)
         run_frame(N'($urandom_range(1, 15)), 9'($urandom_range(0, 511)), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
